icache: RTL
===========

# icache

Two-bank, direct-mapped, read-only instruction cache that answers the instruction fetch stage's single fetch address with a 128-bit fetch group of four consecutive 32-bit instructions starting at that address. The fetch group may cross a line boundary. Hits are served combinationally in the same cycle. Misses are refilled one 16-byte line at a time over a valid/ready request and valid response memory port. The block sits between the fetch stage (core side) and the L2/memory arbiter (memory side).

## Interface
Parameters:
- NUM_SETS, 64: total lines; power of two, ≥4; split evenly across two banks by index LSB.
- LINE_BYTES, 16: fixed; one line equals one fetch group.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core2icache_addr  in  32  fetch address; bits [1:0] ignored
- icache2core_data  out  128  word i (bits [32i+31:32i]) is the instruction at addr+4i
- icache2core_data_valid  out  1  all four words valid this cycle
- flush  in  1  fence.i; invalidate all lines
- icache2mem_req_valid  out  1  refill request
- mem2icache_req_ready  in  1  request accepted
- icache2mem_addr  out  32  line-aligned refill address
- mem2icache_resp_valid  in  1  refill data valid
- mem2icache_resp_data  in  128  refill line, word 0 in bits [31:0]
- perf_hit_count  out  32  see Configuration
- perf_miss_count  out  32  see Configuration

## Operation
- Address split: offset = [3:0], word w = [3:2], index = [log2(NUM_SETS)+3:4], bank = index[0], tag = the remaining upper bits.
- Line A = line containing addr. Line B = A+16, which always falls in the opposite bank. Both banks are looked up every cycle.
- needB = (w != 0). Hit = hitA & (hitB | ~needB).
- Output word i = word (w+i) of the 256-bit concatenation {B,A}. data = 0 whenever valid = 0.
- FSM states:
  - IDLE: on miss and no flush, latch missAddr = (hitA ? B : A) line address, then go to REQ.
  - REQ: req_valid = 1 with icache2mem_addr = missAddr. When ready = 1, go to WAIT.
  - WAIT: on resp_valid, go to FILL. The line is captured unless the refill is marked dropped.
  - FILL: write the tag, data and valid bit of missAddr's set, then return to IDLE. Lookup re-evaluates in the next cycle, and a second line miss starts another refill.
- Valid is 0 in REQ, WAIT and FILL, even if the current address hits.
- Only one refill is outstanding at a time. A change of core2icache_addr during a refill does not cancel it; the refill completes and writes.
- flush: all valid bits are cleared at the clock edge. If flush arrives in REQ or WAIT, the transaction still completes but the refill is marked dropped and nothing is written. Flush in FILL suppresses the write. Flush has priority over a miss in IDLE.

## Timing
- Hit latency: 0 cycles (combinational from addr).
- Miss on one line: REQ ≥1 cycle, WAIT ≥1 cycle, FILL 1 cycle. Valid returns in the cycle after FILL.
- req_valid is held with a stable address until ready is seen; it drops the cycle after handshake.
- Reset: all valid bits = 0, FSM = IDLE, req_valid = 0, icache2mem_addr = 0, data_valid = 0, data = 0, counters = 0.
- Reset mid-refill aborts locally. A late resp_valid arriving in IDLE is ignored, and the memory side must tolerate this.

## Configuration
- ICACHE_PERF_EN defined: perf_hit_count increments on every cycle with data_valid = 1. perf_miss_count increments on every IDLE→REQ transition. Both are 32-bit, wrap, and are cleared by reset only.
- ICACHE_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared header (with other common definitions):
  - ICACHE_NUM_SETS, ICACHE_LINE_BYTES.
  - Derived index/tag widths.
  - icache_state_t enum (IDLE, REQ, WAIT, FILL).
- Sub-module icache_bank: holds NUM_SETS/2 entries of tag, valid and 128-bit data. It has one combinational read port (index → tag, valid, data), one synchronous write port, and a flash-clear input. It is instantiated twice; the top level swaps bank outputs into A/B order by addr bank bit.

## Test plan
- Cold aligned miss, addr 0x1000: req 0x1000 accepted. Resp supplies words 0x13,0x93,0x113,0x193. The cycle after FILL gives valid = 1 and data = {0x193,0x113,0x93,0x13}. perf_miss_count = 1.
- Unaligned 0x100C with line 0x1000 resident: exactly one refill, of 0x1010. Afterwards word0 = line 0x1000 word 3, and words 1–3 = line 0x1010 words 0–2.
- Conflict: after filling 0x1000, fetch 0x1400 (same set, different tag) → miss and refill. Returning to 0x1000 → miss again.
- Flush asserted in WAIT for 0x2000: resp is consumed and no write occurs. The FSM re-requests 0x2000 afterwards, and earlier-resident 0x1000 also misses.
- Reset asserted during WAIT: the next cycle shows IDLE with req_valid = 0, valid = 0 and all lines invalid. A stray resp_valid is ignored.
- Backpressure: ready held 0 for 5 cycles → req_valid and addr stay stable throughout, and the handshake occurs exactly once.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the two-bank instruction cache.
//   ICACHE_NUM_SETS / ICACHE_LINE_BYTES : default geometry
//   ICACHE_INDEX_W / ICACHE_OFFSET_W / ICACHE_TAG_W : derived address field widths
//   icache_state_t : refill FSM states
package icache_pkg;
   localparam int ICACHE_NUM_SETS   = 64;
   localparam int ICACHE_LINE_BYTES = 16;
   localparam int ICACHE_OFFSET_W   = $clog2(ICACHE_LINE_BYTES);
   localparam int ICACHE_INDEX_W    = $clog2(ICACHE_NUM_SETS);
   localparam int ICACHE_TAG_W      = 32 - ICACHE_OFFSET_W - ICACHE_INDEX_W;
   localparam int ICACHE_LINE_BITS  = ICACHE_LINE_BYTES * 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FILL = 2'd3
   } icache_state_t;
endpackage

// File: rtl/icache_bank.sv
// icache_bank: one bank of the direct-mapped instruction cache.
//   clock, reset          : clock, synchronous active-high reset (clears valid bits)
//   clear                 : flash-invalidate every entry at the clock edge
//   rd_idx -> rd_tag/rd_valid/rd_data : combinational lookup
//   wr_en/wr_idx/wr_tag/wr_data       : synchronous line install (sets valid)
module icache_bank
   import icache_pkg::*;
#(
   parameter int SETS  = ICACHE_NUM_SETS / 2,
   parameter int IDX_W = $clog2(SETS),
   parameter int TAG_W = ICACHE_TAG_W
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic [IDX_W-1:0]            rd_idx,
   output logic [TAG_W-1:0]            rd_tag,
   output logic                        rd_valid,
   output logic [ICACHE_LINE_BITS-1:0] rd_data,
   input  logic                        wr_en,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [TAG_W-1:0]            wr_tag,
   input  logic [ICACHE_LINE_BITS-1:0] wr_data
);
   logic [SETS-1:0]             valid_q;
   logic [TAG_W-1:0]            tag_q  [SETS];
   logic [ICACHE_LINE_BITS-1:0] data_q [SETS];

   // Clear wins over a same-cycle write; the top never issues both anyway.
   always_ff @(posedge clock) begin
      if (reset || clear)
         valid_q <= '0;
      else if (wr_en)
         valid_q[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// icache: two-bank direct-mapped read-only instruction cache.
// Returns four consecutive instructions starting at core2icache_addr; the group
// may straddle two lines (A = line of addr, B = A+1, always in opposite banks).
// Hits are combinational; misses refill one line at a time.
//   core side  : core2icache_addr, icache2core_data, icache2core_data_valid, flush
//   memory side: icache2mem_req_valid/mem2icache_req_ready/icache2mem_addr,
//                mem2icache_resp_valid/mem2icache_resp_data
//   perf       : perf_hit_count, perf_miss_count (live only with ICACHE_PERF_EN)
// Optional build macro: ICACHE_PERF_EN enables the hit/miss counters.
module icache
   import icache_pkg::*;
#(
   parameter int NUM_SETS   = ICACHE_NUM_SETS,
   parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [31:0]  core2icache_addr,
   output logic [127:0] icache2core_data,
   output logic         icache2core_data_valid,
   input  logic         flush,
   output logic         icache2mem_req_valid,
   input  logic         mem2icache_req_ready,
   output logic [31:0]  icache2mem_addr,
   input  logic         mem2icache_resp_valid,
   input  logic [127:0] mem2icache_resp_data,
   output logic [31:0]  perf_hit_count,
   output logic [31:0]  perf_miss_count
);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int LINE_W = 32 - OFF_W;        // line address width
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int BIDX_W = IDX_W - 1;         // index within a bank
   localparam int TAG_W  = LINE_W - IDX_W;

   icache_state_t     state;
   logic [LINE_W-1:0] miss_line;
   logic              dropped;
   logic [127:0]      fill_data;

   logic [LINE_W-1:0] line_a, line_b, miss_next;
   logic              bank_a;
   logic [1:0]        word_sel;
   logic              hit_a, hit_b, need_b, hit, fill_we;
   logic              unused_addr_bits;

   logic [1:0][LINE_W-1:0] bank_line;
   logic [1:0][TAG_W-1:0]  rd_tag;
   logic [1:0]             rd_valid;
   logic [1:0][127:0]      rd_data;
   logic [1:0]             bank_hit;
   logic [255:0]           group;

   assign unused_addr_bits = ^core2icache_addr[1:0];

   assign line_a   = core2icache_addr[31:OFF_W];
   assign line_b   = line_a + {{(LINE_W-1){1'b0}}, 1'b1};
   assign bank_a   = line_a[0];
   assign word_sel = core2icache_addr[3:2];

   // Each bank looks up whichever of A/B maps to it.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_line[b] = (bank_a == 1'(b)) ? line_a : line_b;
      assign bank_hit[b]  = rd_valid[b] && (rd_tag[b] == bank_line[b][LINE_W-1:IDX_W]);

      icache_bank #(
         .SETS  (NUM_SETS / 2),
         .IDX_W (BIDX_W),
         .TAG_W (TAG_W)
      ) u_bank (
         .clock    (clock),
         .reset    (reset),
         .clear    (flush),
         .rd_idx   (bank_line[b][IDX_W-1:1]),
         .rd_tag   (rd_tag[b]),
         .rd_valid (rd_valid[b]),
         .rd_data  (rd_data[b]),
         .wr_en    (fill_we && (miss_line[0] == 1'(b))),
         .wr_idx   (miss_line[IDX_W-1:1]),
         .wr_tag   (miss_line[LINE_W-1:IDX_W]),
         .wr_data  (fill_data)
      );
   end

   assign hit_a  = bank_hit[bank_a];
   assign hit_b  = bank_hit[~bank_a];
   assign need_b = (word_sel != 2'd0);
   assign hit    = hit_a && (hit_b || !need_b);

   // Rotate {B,A} so word i of the output is word (w+i) of the pair.
   assign group = {rd_data[~bank_a], rd_data[bank_a]};

   assign icache2core_data_valid = (state == IDLE) && hit;
   assign icache2core_data       = icache2core_data_valid ?
                                   group[{1'b0, word_sel, 5'b0} +: 128] : '0;

   // If A is present the miss must be on B.
   assign miss_next = hit_a ? line_b : line_a;

   // A flush in the install cycle also suppresses the write.
   assign fill_we = (state == FILL) && !dropped && !flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         state                <= IDLE;
         icache2mem_req_valid <= 1'b0;
         icache2mem_addr      <= '0;
         miss_line            <= '0;
         dropped              <= 1'b0;
         fill_data            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush && !hit) begin
                  miss_line            <= miss_next;
                  icache2mem_addr      <= {miss_next, {OFF_W{1'b0}}};
                  icache2mem_req_valid <= 1'b1;
                  dropped              <= 1'b0;
                  state                <= REQ;
               end
            end
            REQ: begin
               if (flush) dropped <= 1'b1;
               if (mem2icache_req_ready) begin
                  icache2mem_req_valid <= 1'b0;
                  state                <= WAIT;
               end
            end
            WAIT: begin
               if (flush) dropped <= 1'b1;
               if (mem2icache_resp_valid) begin
                  fill_data <= mem2icache_resp_data;
                  state     <= FILL;
               end
            end
            FILL: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (icache2core_data_valid)
            hit_cnt <= hit_cnt + 32'd1;
         if (state == IDLE && !flush && !hit)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end

   assign perf_hit_count  = hit_cnt;
   assign perf_miss_count = miss_cnt;
`else
   assign perf_hit_count  = '0;
   assign perf_miss_count = '0;
`endif
endmodule
